// File: rtl/audio_nios_pio_ext.sv
// audio_nios_pio_ext
//   Avalon-MM PIO slave for board LEDs, push-buttons and switches.
//   Provides an output register with atomic set/clear and a per-bit
//   hardware blink generator driven by a programmable prescaler. Also
//   provides a synchronised input port with edge capture, a maskable
//   level interrupt, and zero-wait-state reads.
//
// Ports
//   clk         system clock, all logic on rising edge
//   reset_n     asynchronous active-low reset
//   address     word address of register (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above a register's width ignored)
//   readdata    read data, combinational from address
//   in_port     asynchronous external inputs
//   out_port    driven outputs
//   irq         active-high level interrupt
//
// Bus semantics: there is no valid/ready stall. A write is accepted in
// every cycle where chipselect=1 and write_n=0, and it takes effect on the
// next rising clk edge. A read is always ready: readdata follows address
// combinationally and has no side effects.
//
// Register map
//   0 DATA      RW   1 INPUT   RO   2 IRQMASK  RW   3 EDGECAP  W1C
//   4 SET       WO   5 CLR     WO   6 BLINK_EN RW   7 PRESCALE RW
module audio_nios_pio_ext #(
  parameter int                   OUT_WIDTH      = 26,
  parameter int                   IN_WIDTH       = 4,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE    = '0,
  parameter int                   EDGE_TYPE      = 0,
  parameter int                   PRESCALE_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE = PRESCALE_WIDTH'(1);

  logic [OUT_WIDTH-1:0]      r_data;
  logic [OUT_WIDTH-1:0]      r_blink_en;
  logic [IN_WIDTH-1:0]       r_irqmask;
  logic [IN_WIDTH-1:0]       r_edgecap;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_counter;
  logic                      r_phase;
  logic [IN_WIDTH-1:0]       r_sync1;
  logic [IN_WIDTH-1:0]       r_sync2;
  logic [IN_WIDTH-1:0]       r_prev;

  logic                      w_wr;
  logic [OUT_WIDTH-1:0]      w_wdata_out;
  logic [IN_WIDTH-1:0]       w_wdata_in;
  logic [PRESCALE_WIDTH-1:0] w_wdata_ps;
  logic [IN_WIDTH-1:0]       w_edge;
  logic [IN_WIDTH-1:0]       w_cap_clr;

  assign w_wr        = chipselect & ~write_n;
  assign w_wdata_out = writedata[OUT_WIDTH-1:0];
  assign w_wdata_in  = writedata[IN_WIDTH-1:0];
  assign w_wdata_ps  = writedata[PRESCALE_WIDTH-1:0];

  // Bits being cleared by a write of 1 to EDGECAP this cycle.
  assign w_cap_clr = (w_wr && address == 3'd3) ? w_wdata_in : '0;

  always_comb begin
    case (EDGE_TYPE)
      0:       w_edge = r_sync2 & ~r_prev;
      1:       w_edge = ~r_sync2 & r_prev;
      default: w_edge = r_sync2 ^ r_prev;
    endcase
  end

  // Input synchroniser (2 flops) plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Bus-writable registers. DATA is also the target of SET and CLR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_irqmask  <= '0;
      r_blink_en <= '0;
      r_prescale <= '0;
    end else if (w_wr) begin
      case (address)
        3'd0:    r_data     <= w_wdata_out;
        3'd2:    r_irqmask  <= w_wdata_in;
        3'd4:    r_data     <= r_data | w_wdata_out;
        3'd5:    r_data     <= r_data & ~w_wdata_out;
        3'd6:    r_blink_en <= w_wdata_out;
        3'd7:    r_prescale <= w_wdata_ps;
        default: ;
      endcase
    end
  end

  // A freshly detected edge wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= w_edge | (r_edgecap & ~w_cap_clr);
    end
  end

  // Blink prescaler. The >= compare recovers immediately when PRESCALE is
  // lowered below the running count. A PRESCALE write restarts the count
  // without disturbing the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_phase   <= 1'b1;
    end else if (w_wr && address == 3'd7) begin
      r_counter <= '0;
    end else if (r_counter >= r_prescale) begin
      r_counter <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_counter <= r_counter + PS_ONE;
    end
  end

  assign out_port = r_data & (~r_blink_en | {OUT_WIDTH{r_phase}});
  assign irq      = |(r_edgecap & r_irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[OUT_WIDTH-1:0]      = r_data;
      3'd1:    readdata[IN_WIDTH-1:0]       = r_sync2;
      3'd2:    readdata[IN_WIDTH-1:0]       = r_irqmask;
      3'd3:    readdata[IN_WIDTH-1:0]       = r_edgecap;
      3'd6:    readdata[OUT_WIDTH-1:0]      = r_blink_en;
      3'd7:    readdata[PRESCALE_WIDTH-1:0] = r_prescale;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_audio_nios_pio_ext.sv
// tb_audio_nios_pio_ext
//   Directed bench for audio_nios_pio_ext. Inputs are driven on the
//   falling clk edge and outputs sampled there too, half a period away
//   from the rising edge where the DUT updates.
module tb_audio_nios_pio_ext;

  localparam int OW = 26;
  localparam int IW = 4;
  localparam logic [31:0] RV = 32'h155;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [IW-1:0] in_port = '0;
  logic [OW-1:0] out_port;
  logic          irq;

  int total = 0;
  int bad   = 0;
  logic v0;

  always #5 clk = ~clk;

  audio_nios_pio_ext #(
    .OUT_WIDTH      (OW),
    .IN_WIDTH       (IW),
    .RESET_VALUE    (26'h155),
    .EDGE_TYPE      (0),
    .PRESCALE_WIDTH (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [2:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
    check(tag, d, exp);
  endtask

  initial begin
    // reset state
    tick(2);
    check("rst_out", {6'b0, out_port}, RV);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check_rd("rst_rd2", 3'd2, 32'h0);
    check_rd("rst_rd3", 3'd3, 32'h0);
    check_rd("rst_rd6", 3'd6, 32'h0);
    check_rd("rst_rd7", 3'd7, 32'h0);
    check_rd("rst_rd0", 3'd0, RV);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check("rel_out", {6'b0, out_port}, RV);

    // set / clear
    wr(3'd0, 32'h0F0);
    check("data_out", {6'b0, out_port}, 32'h0F0);
    wr(3'd4, 32'h003);
    check("set_out", {6'b0, out_port}, 32'h0F3);
    wr(3'd5, 32'h010);
    check("clr_out", {6'b0, out_port}, 32'h0E3);
    check_rd("rd_set", 3'd4, 32'h0);
    check_rd("rd_clr", 3'd5, 32'h0);
    check_rd("rd_data", 3'd0, 32'h0E3);
    wr(3'd0, 32'hFC00_0000);  // bits above width ignored
    check("wide_wr", {6'b0, out_port}, 32'h0);

    // blink: PRESCALE=4 -> toggle every 5 clks
    wr(3'd0, 32'h1);
    wr(3'd6, 32'h1);
    wr(3'd7, 32'h4);
    v0 = out_port[0];
    check("blink_hi_bits", {6'b0, out_port[OW-1:1], 1'b0}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("blink_hold_a", {31'b0, out_port[0]}, {31'b0, v0});
    end
    tick(1);
    check("blink_tog_5", {31'b0, out_port[0]}, {31'b0, ~v0});
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("blink_hold_b", {31'b0, out_port[0]}, {31'b0, ~v0});
    end
    tick(1);
    check("blink_tog_10", {31'b0, out_port[0]}, {31'b0, v0});
    tick(3);  // counter now 3
    wr(3'd7, 32'h1);
    check("ps_wr_phase", {31'b0, out_port[0]}, {31'b0, v0});
    tick(1);
    check("ps_wr_hold", {31'b0, out_port[0]}, {31'b0, v0});
    tick(1);
    check("ps_wr_tog", {31'b0, out_port[0]}, {31'b0, ~v0});
    check_rd("rd_ps", 3'd7, 32'h1);
    wr(3'd6, 32'h0);

    // edge capture
    in_port = 4'b0100;
    tick(2);
    check_rd("input_2clk", 3'd1, 32'h4);
    check_rd("cap_not_yet", 3'd3, 32'h0);
    tick(1);
    check_rd("cap_3clk", 3'd3, 32'h4);
    check("irq_masked", {31'b0, irq}, 32'h0);
    wr(3'd2, 32'h4);
    check("irq_on", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h4);
    check_rd("cap_cleared", 3'd3, 32'h0);
    check("irq_off", {31'b0, irq}, 32'h0);

    // simultaneous clear and new edge: edge wins
    in_port = 4'b0000;
    tick(4);
    check_rd("fall_ignored", 3'd3, 32'h0);
    in_port = 4'b0100;
    tick(3);
    check("irq_again", {31'b0, irq}, 32'h1);
    in_port = 4'b0000;
    tick(4);
    in_port = 4'b0100;
    tick(2);  // edge detected during the coming rising edge
    wr(3'd3, 32'h4);
    check_rd("clr_vs_edge", 3'd3, 32'h4);
    check("irq_kept", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h4);
    check_rd("clr_after", 3'd3, 32'h0);

    // async reset mid-blink with EDGECAP=4
    in_port = 4'b0000;
    tick(4);
    in_port = 4'b0100;
    tick(3);
    wr(3'd0, 32'h3);
    wr(3'd6, 32'h3);
    check_rd("cap_pre_rst", 3'd3, 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out", {6'b0, out_port}, RV);
    check("arst_irq", {31'b0, irq}, 32'h0);
    check_rd("arst_input", 3'd1, 32'h0);
    check_rd("arst_blink", 3'd6, 32'h0);
    tick(1);
    reset_n = 1'b1;
    check("arst_rel_out", {6'b0, out_port}, RV);
    // phase=1 at release, toggles every edge with PRESCALE=0
    wr(3'd6, 32'h1);
    check("phase_after1", {6'b0, out_port}, RV & ~32'h1);
    tick(1);
    check("phase_after2", {6'b0, out_port}, RV);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_nios_pio_ext.md
Name: audio_nios_pio_ext

Overview:
Parametrised Avalon-MM PIO slave that succeeds the fixed 26-bit LED output PIO. It provides an output register of configurable width with atomic set and clear, and a per-bit hardware blink generator with a programmable prescaler. It also provides a synchronised input port with edge capture, a maskable interrupt, and zero-wait-state reads. The block sits on the Nios II data master bus and drives board LEDs while sampling push-buttons and switches.

Parameters:
OUT_WIDTH, 26, width of out_port and of the DATA, SET, CLR and BLINK_EN registers (1..32)
IN_WIDTH, 4, width of in_port and of the IRQMASK and EDGECAP registers (1..32)
RESET_VALUE, 0, reset value of the DATA register (OUT_WIDTH bits)
EDGE_TYPE, 0, edge detected by capture: 0 rising, 1 falling, 2 any
PRESCALE_WIDTH, 24, width of the blink prescaler register and counter (1..32)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address, zero wait states
in_port  in  IN_WIDTH  asynchronous external inputs
out_port  out  OUT_WIDTH  driven outputs
irq  out  1  active-high level interrupt

Behaviour:
- Reset values: DATA=RESET_VALUE; IRQMASK=0; EDGECAP=0; BLINK_EN=0; PRESCALE=0; counter=0; phase=1; synchroniser flops=0.
- Consequences at reset: out_port=RESET_VALUE; irq=0.
- Write condition: wr = chipselect & ~write_n. Registers update on the next rising clk edge.
- Register map (word address):
  - 0 DATA: RW, OUT_WIDTH bits.
  - 1 INPUT: RO, synchronised in_port.
  - 2 IRQMASK: RW.
  - 3 EDGECAP: read returns captured bits; writing 1 to a bit clears it.
  - 4 SET: WO; DATA <= DATA | writedata.
  - 5 CLR: WO; DATA <= DATA & ~writedata.
  - 6 BLINK_EN: RW.
  - 7 PRESCALE: RW; a write also zeroes the counter.
- Reads: readdata = selected register zero-extended to 32 bits. Addresses 4 and 5 read 0. Reads have no side effects.
- Input path: 2-flop synchroniser followed by one delay flop (prev).
  - Rising edge = sync & ~prev; falling = ~sync & prev; any = sync ^ prev.
  - An in_port change is visible at INPUT after 2 clks. The EDGECAP bit sets 3 clks after the change.
- EDGECAP update per bit: next = detected_edge | (cap & ~(wr & addr==3 & writedata[i])). A new edge in the same cycle as a clear wins (bit stays set).
- irq = |(EDGECAP & IRQMASK). It is combinational from registers and needs no clk.
- Blink generator:
  - Each clk: if counter >= PRESCALE then counter <= 0 and phase <= ~phase, else counter <= counter+1.
  - PRESCALE=0 toggles phase every cycle.
  - The >= comparison guarantees recovery when PRESCALE is lowered below the current counter.
  - A PRESCALE write forces counter <= 0 and leaves phase unchanged.
  - The phase period is 2*(PRESCALE+1) clks.
- Output: out_port = DATA & (~BLINK_EN | {OUT_WIDTH{phase}}). It is registered-source combinational and carries no extra latency beyond the register update.
- Write data bits above a register's width are ignored.
- Reset asserted mid-operation returns every register, counter and the phase to its reset value immediately (asynchronously). Captured edges are lost.

Test Plan:
- Reset: hold reset_n=0, RESET_VALUE=26'h155 -> out_port=26'h155, irq=0, read addr 2/3/6/7 returns 0; release reset, no change.
- Set/clear: write DATA=26'h00F0, SET 26'h0003, CLR 26'h0010 -> out_port sequence 0F0, 0F3, 0E3, each one clk after its write; read addr 4 returns 0.
- Blink: DATA=26'h1, BLINK_EN=1, PRESCALE=4 -> out_port[0] toggles every 5 clks (period 10). Then write PRESCALE=1 with counter at 3 -> counter restarts at 0, toggle after 2 clks.
- Edge capture (EDGE_TYPE=0): in_port[2] 0->1 with IRQMASK=0 -> EDGECAP=4 after 3 clks, irq=0. Write IRQMASK=4 -> irq=1. Write 4 to addr 3 -> EDGECAP=0, irq=0.
- Simultaneous clear and edge: time the addr-3 write of 1 to coincide with a new detected edge on the same bit -> bit remains 1, irq stays high.
- Async reset mid-blink with EDGECAP=4 -> out_port=RESET_VALUE, irq=0 within the same cycle; phase=1 after release.
